// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between fetch and MEM stage.
// Ports: if_* fetch side, d_* data side, mem_* memory side, stall_*, halt_in/halt_out.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  input  logic        halt_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        halt_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;

  logic pick_any;
  logic pick_d;
  logic misal;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    pick_any = if_req | d_req;
    pick_d   = d_req & (~if_req | (last_grant == FETCH));
    misal    = 1'b0;
    if (pick_d) begin
      case (d_size)
        2'b00:   misal = 1'b0;
        2'b01:   misal = d_addr[0];
        2'b10:   misal = |d_addr[1:0];
        default: misal = 1'b1;
      endcase
    end else begin
      misal = |if_addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= FETCH;
      owner      <= FETCH;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_size   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      halt_out   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (halt_in) begin
            halt_out <= 1'b1;
            state    <= HALT;
          end else if (pick_any) begin
            if (misal) begin
              halt_out <= 1'b1;
              state    <= HALT;
            end else begin
              mem_req    <= 1'b1;
              owner      <= pick_d;
              last_grant <= pick_d;
              cnt        <= '0;
              state      <= WAIT;
              if (pick_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_size  <= d_size;
                mem_wdata <= d_wdata;
              end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_size  <= 2'b10;
                mem_wdata <= '0;
              end
            end
          end
        end
        WAIT: begin
          // halt_in is latched but the access in flight still finishes.
          if (halt_in) halt_out <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
            if (owner == DATA) begin
              d_valid <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            halt_out <= 1'b1;
            state    <= HALT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= halt_out ? HALT : IDLE;
        end
        default: begin
          mem_req  <= 1'b0;
          halt_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random + directed bench for mem_port_arbiter.
// Transaction-level model predicts every output; a negedge process compares.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        halt_in = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        halt_out;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_size(d_size), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .halt_in(halt_in),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .halt_out(halt_out)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // expected outputs
  logic        e_mem_req, e_mem_we;
  logic [31:0] e_mem_addr, e_mem_wdata;
  logic [1:0]  e_mem_size;
  logic [31:0] e_if_rdata, e_d_rdata;
  logic        e_if_valid, e_d_valid, e_halt;
  // model bookkeeping
  bit m_busy, m_who, m_last_data;
  int m_waited;

  // memory responder knobs
  bit          ack_en = 0;
  bit          armed = 0;
  int          dly = 0;
  int          fix_dly = -1;
  bit          fix_rdata_en = 0;
  logic [31:0] fix_rdata = '0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_mem_req = 0; e_mem_we = 0; e_mem_addr = 0;
    e_mem_wdata = 0; e_mem_size = 0;
    e_if_rdata = 0; e_d_rdata = 0;
    e_if_valid = 0; e_d_valid = 0; e_halt = 0;
    m_busy = 0; m_who = 0; m_last_data = 0; m_waited = 0;
  endtask

  function automatic bit bad_access(bit take_d);
    int unsigned bytes;
    if (!take_d) return (if_addr % 4) != 0;
    if (d_size == 2'b11) return 1'b1;
    bytes = 1 << d_size;
    return (d_addr % bytes) != 0;
  endfunction

  // One clock edge of the port, seen as transactions.
  task automatic model_edge();
    bit pulsed;
    bit take_d;
    pulsed = e_if_valid | e_d_valid;
    e_if_valid = 0;
    e_d_valid = 0;
    if (m_busy) begin
      if (halt_in) e_halt = 1;
      if (mem_ack) begin
        m_busy = 0;
        e_mem_req = 0;
        if (m_who) begin
          e_d_valid = 1;
          if (!e_mem_we) e_d_rdata = mem_rdata;
        end else begin
          e_if_valid = 1;
          e_if_rdata = mem_rdata;
        end
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          m_busy = 0;
          e_mem_req = 0;
          e_halt = 1;
        end
      end
    end else if (pulsed || e_halt) begin
      // settle cycle after a completion, or halted for good
    end else if (halt_in) begin
      e_halt = 1;
    end else if (if_req || d_req) begin
      take_d = d_req && !(if_req && m_last_data);
      if (bad_access(take_d)) begin
        e_halt = 1;
      end else begin
        if (take_d) begin
          e_mem_we = d_we; e_mem_addr = d_addr;
          e_mem_size = d_size; e_mem_wdata = d_wdata;
        end else begin
          e_mem_we = 0; e_mem_addr = if_addr;
          e_mem_size = 2'b10; e_mem_wdata = 0;
        end
        e_mem_req = 1;
        m_busy = 1;
        m_who = take_d;
        m_last_data = take_d;
        m_waited = 0;
      end
    end
  endtask

  task automatic responder();
    if (mem_ack) begin
      mem_ack = 0;
    end else if (ack_en && mem_req) begin
      if (!armed) begin
        armed = 1;
        dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
      end
      if (dly == 0) begin
        mem_ack = 1;
        armed = 0;
      end else begin
        dly--;
      end
    end
    mem_rdata = fix_rdata_en ? fix_rdata : $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) model_edge();
    responder();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    mem_ack = 0; armed = 0;
    if_req = 0; d_req = 0; halt_in = 0; d_we = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, e_mem_req);
      check("mem_we", mem_we, e_mem_we);
      check("mem_addr", mem_addr, e_mem_addr);
      check("mem_size", mem_size, e_mem_size);
      check("mem_wdata", mem_wdata, e_mem_wdata);
      check("if_rdata", if_rdata, e_if_rdata);
      check("d_rdata", d_rdata, e_d_rdata);
      check("if_valid", if_valid, e_if_valid);
      check("d_valid", d_valid, e_d_valid);
      check("halt_out", halt_out, e_halt);
      check("stall_if", stall_if, if_req & ~e_if_valid);
      check("stall_mem", stall_mem, d_req & ~e_d_valid);
    end
  end

  int          nv, seen, hi, reqs;
  bit          prev;
  logic [31:0] order[$];
  logic [31:0] exp_ord[4];
  int          done_cnt;

  initial begin
    model_reset();
    #2;
    do_reset();
    chk_en = 1;

    // reset state
    @(negedge clk);
    check("rst_halt", halt_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_valid", {if_valid, d_valid}, 0);

    // single load
    ack_en = 1; fix_dly = 1;
    fix_rdata_en = 1; fix_rdata = 32'hDEADBEEF;
    d_req = 1; d_we = 0; d_addr = 32'h100;
    d_size = 2'b10; d_wdata = 0;
    nv = 0; seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (d_valid) d_req = 0;
      @(negedge clk);
      if (mem_req) begin
        check("ld_addr", mem_addr, 32'h100);
        check("ld_size", mem_size, 2'b10);
        check("ld_we", mem_we, 0);
        seen++;
      end
      nv += int'(d_valid);
    end
    check("ld_issued", seen != 0, 1);
    check("ld_pulses", nv, 1);
    check("ld_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_stall", stall_mem, 0);
    fix_rdata_en = 0;

    // contention from reset, immediate acks
    do_reset();
    fix_dly = 0;
    if_req = 1; if_addr = 32'h200;
    d_req = 1; d_addr = 32'h300; d_size = 2'b10;
    prev = 0; nv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      @(negedge clk);
      if (mem_req && !prev) order.push_back(mem_addr);
      prev = mem_req;
      nv += int'(if_valid) + int'(d_valid);
      if (i == 0) check("ct_stall_if", stall_if, 1);
    end
    exp_ord[0] = 32'h300; exp_ord[1] = 32'h200;
    exp_ord[2] = 32'h300; exp_ord[3] = 32'h200;
    check("ct_count", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++)
      check("ct_order", order[k], exp_ord[k]);
    check("ct_pulses", nv, 4);

    // random traffic
    do_reset();
    fix_dly = -1;
    done_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (e_if_valid) begin
        if_req = 0;
        done_cnt++;
      end
      if (e_d_valid) begin
        d_req = 0;
        done_cnt++;
      end
      if (!if_req && $urandom_range(0, 1) == 0) begin
        if_req = 1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1;
        d_we = 1'($urandom);
        d_size = 2'($urandom_range(0, 2));
        d_addr = $urandom;
        if (d_size == 2'b01) d_addr[0] = 1'b0;
        if (d_size == 2'b10) d_addr[1:0] = 2'b00;
        d_wdata = $urandom;
      end
    end
    @(negedge clk);
    check("rnd_no_halt", halt_out, 0);
    check("rnd_progress", done_cnt > 400, 1);

    // misaligned half
    do_reset();
    ack_en = 1;
    d_req = 1; d_size = 2'b01; d_addr = 32'h101; d_we = 0;
    step();
    @(negedge clk);
    check("mis_halt", halt_out, 1);
    if_req = 1; if_addr = 32'h0;
    reqs = 0; nv = 0;
    repeat (6) begin
      step();
      @(negedge clk);
      reqs += int'(mem_req);
      nv += int'(d_valid) + int'(if_valid);
    end
    check("mis_noreq", reqs, 0);
    check("mis_novalid", nv, 0);
    check("mis_stall_if", stall_if, 1);
    check("mis_halt_hold", halt_out, 1);

    // timeout
    do_reset();
    ack_en = 0;
    d_req = 1; d_size = 2'b10; d_addr = 32'h80; d_we = 0;
    hi = 0;
    repeat (25) begin
      step();
      @(negedge clk);
      hi += int'(mem_req);
    end
    check("to_req_cycles", hi, TIMEOUT);
    check("to_halt", halt_out, 1);
    mem_ack = 1;
    nv = 0;
    repeat (4) begin
      step();
      @(negedge clk);
      nv += int'(d_valid);
    end
    check("to_late_ack", nv, 0);

    // halt_in during WAIT
    do_reset();
    ack_en = 0;
    d_req = 1; d_size = 2'b10; d_addr = 32'h84; d_we = 0;
    step();
    @(negedge clk);
    check("hm_req", mem_req, 1);
    halt_in = 1;
    step();
    @(negedge clk);
    check("hm_halt_now", halt_out, 1);
    check("hm_req_hold", mem_req, 1);
    halt_in = 0;
    step();
    step();
    mem_ack = 1;
    mem_rdata = 32'hCAFE0001;
    step();
    @(negedge clk);
    check("hm_valid", d_valid, 1);
    check("hm_rdata", d_rdata, 32'hCAFE0001);
    d_req = 0;
    reqs = 0;
    repeat (8) begin
      step();
      d_req = 1;
      @(negedge clk);
      reqs += int'(mem_req);
    end
    check("hm_noreq", reqs, 0);
    check("hm_halt_hold", halt_out, 1);

    // reset during WAIT, then a store
    do_reset();
    ack_en = 0;
    d_req = 1; d_size = 2'b10; d_addr = 32'h88;
    step();
    step();
    @(negedge clk);
    check("rm_req", mem_req, 1);
    #2;
    rst_n = 0;
    #1;
    check("rm_async_drop", mem_req, 0);
    do_reset();
    ack_en = 1; fix_dly = 0;
    d_req = 1; d_we = 1; d_wdata = 32'h12345678;
    d_size = 2'b10; d_addr = 32'h40;
    seen = 0; nv = 0;
    repeat (6) begin
      step();
      if (d_valid) d_req = 0;
      @(negedge clk);
      if (mem_req) begin
        check("st_wdata", mem_wdata, 32'h12345678);
        check("st_we", mem_we, 1);
        check("st_addr", mem_addr, 32'h40);
        seen++;
      end
      nv += int'(d_valid);
    end
    check("st_issue", seen, 1);
    check("st_pulse", nv, 1);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
